// File: rtl/id_stage.sv
// RV32I decode stage: register file with write-through bypass, control and immediate
// decode, and the ID/EX pipeline register feeding execute.
module id_stage (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] InstrD,
    input  logic [31:0] PCD,
    input  logic [31:0] PCPlus4D,
    input  logic        RegWriteW,
    input  logic [4:0]  RdW,
    input  logic [31:0] ResultW,
    input  logic        FlushE,
    output logic [4:0]  Rs1D,
    output logic [4:0]  Rs2D,
    output logic [31:0] RD1E,
    output logic [31:0] RD2E,
    output logic [31:0] ImmExtE,
    output logic [31:0] PCE,
    output logic [31:0] PCPlus4E,
    output logic [4:0]  Rs1E,
    output logic [4:0]  Rs2E,
    output logic [4:0]  RdE,
    output logic        RegWriteE,
    output logic [1:0]  ResultSrcE,
    output logic        MemWriteE,
    output logic        JumpE,
    output logic        BranchE,
    output logic [2:0]  ALUControlE,
    output logic        ALUSrcE,
    output logic        IllegalE
);
    localparam int unsigned XLEN  = 32;
    localparam int unsigned NREGS = 32;
    localparam int unsigned AW    = 5;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [AW-1:0]   rd;
    logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_j;

    logic [XLEN-1:0] regs [NREGS];
    logic [XLEN-1:0] rd1, rd2;

    logic            reg_write, mem_write, jump, branch, alu_src, illegal, alu_by_funct3;
    logic [1:0]      result_src;
    logic [2:0]      alu_ctrl;
    logic [XLEN-1:0] imm;

    assign opcode = InstrD[6:0];
    assign funct3 = InstrD[14:12];
    assign rd     = InstrD[11:7];
    assign Rs1D   = InstrD[19:15];
    assign Rs2D   = InstrD[24:20];

    assign imm_i = {{20{InstrD[31]}}, InstrD[31:20]};
    assign imm_s = {{20{InstrD[31]}}, InstrD[31:25], InstrD[11:7]};
    assign imm_b = {{19{InstrD[31]}}, InstrD[31], InstrD[7], InstrD[30:25], InstrD[11:8], 1'b0};
    assign imm_j = {{11{InstrD[31]}}, InstrD[31], InstrD[19:12], InstrD[20], InstrD[30:21], 1'b0};

    // Register file; x0 is never written and reads of it are forced to zero below.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < NREGS; i++) begin
                regs[AW'(i)] <= '0;
            end
        end else if (RegWriteW && (RdW != '0)) begin
            regs[RdW] <= ResultW;
        end
    end

    // Same-cycle writeback bypass so a value written this edge is seen by the reader.
    always_comb begin
        rd1 = regs[Rs1D];
        rd2 = regs[Rs2D];
        if (RegWriteW && (RdW != '0) && (RdW == Rs1D)) rd1 = ResultW;
        if (RegWriteW && (RdW != '0) && (RdW == Rs2D)) rd2 = ResultW;
        if (Rs1D == '0) rd1 = '0;
        if (Rs2D == '0) rd2 = '0;
    end

    // Main and ALU control decode plus immediate selection.
    always_comb begin
        reg_write     = 1'b0;
        result_src    = 2'b00;
        mem_write     = 1'b0;
        jump          = 1'b0;
        branch        = 1'b0;
        alu_src       = 1'b0;
        alu_ctrl      = ALU_ADD;
        illegal       = 1'b0;
        alu_by_funct3 = 1'b0;
        imm           = '0;
        case (opcode)
            OP_LW: begin
                reg_write  = 1'b1;
                result_src = 2'b01;
                alu_src    = 1'b1;
                imm        = imm_i;
            end
            OP_SW: begin
                mem_write = 1'b1;
                alu_src   = 1'b1;
                imm       = imm_s;
            end
            OP_R: begin
                reg_write     = 1'b1;
                alu_by_funct3 = 1'b1;
            end
            OP_I: begin
                reg_write     = 1'b1;
                alu_src       = 1'b1;
                alu_by_funct3 = 1'b1;
                imm           = imm_i;
            end
            OP_BEQ: begin
                branch   = 1'b1;
                alu_ctrl = ALU_SUB;
                imm      = imm_b;
            end
            OP_JAL: begin
                reg_write  = 1'b1;
                jump       = 1'b1;
                result_src = 2'b10;
                imm        = imm_j;
            end
            default: illegal = 1'b1;
        endcase
        if (alu_by_funct3) begin
            case (funct3)
                3'b000:  alu_ctrl = (opcode == OP_R && InstrD[30]) ? ALU_SUB : ALU_ADD;
                3'b010:  alu_ctrl = ALU_SLT;
                3'b110:  alu_ctrl = ALU_OR;
                3'b111:  alu_ctrl = ALU_AND;
                default: begin
                    alu_ctrl = ALU_ADD;
                    illegal  = 1'b1;
                end
            endcase
        end
    end

    // ID/EX register; a flush only kills the control bits, data is don't-care in a bubble.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            RD1E        <= '0;
            RD2E        <= '0;
            ImmExtE     <= '0;
            PCE         <= '0;
            PCPlus4E    <= '0;
            Rs1E        <= '0;
            Rs2E        <= '0;
            RdE         <= '0;
            RegWriteE   <= 1'b0;
            ResultSrcE  <= 2'b00;
            MemWriteE   <= 1'b0;
            JumpE       <= 1'b0;
            BranchE     <= 1'b0;
            ALUControlE <= 3'b000;
            ALUSrcE     <= 1'b0;
            IllegalE    <= 1'b0;
        end else begin
            RD1E     <= rd1;
            RD2E     <= rd2;
            ImmExtE  <= imm;
            PCE      <= PCD;
            PCPlus4E <= PCPlus4D;
            Rs1E     <= Rs1D;
            Rs2E     <= Rs2D;
            RdE      <= rd;
            if (FlushE) begin
                RegWriteE   <= 1'b0;
                ResultSrcE  <= 2'b00;
                MemWriteE   <= 1'b0;
                JumpE       <= 1'b0;
                BranchE     <= 1'b0;
                ALUControlE <= 3'b000;
                ALUSrcE     <= 1'b0;
                IllegalE    <= 1'b0;
            end else begin
                RegWriteE   <= reg_write;
                ResultSrcE  <= result_src;
                MemWriteE   <= mem_write;
                JumpE       <= jump;
                BranchE     <= branch;
                ALUControlE <= alu_ctrl;
                ALUSrcE     <= alu_src;
                IllegalE    <= illegal;
            end
        end
    end
endmodule

// File: tb/tb_id_stage.sv
// Scoreboard bench for id_stage: instructions are assembled from mnemonic-level fields and
// the expected ID/EX contents come from those fields plus an architectural register model.
module tb_id_stage;
    localparam int K_LW = 0, K_SW = 1, K_R = 2, K_I = 3, K_BEQ = 4, K_JAL = 5, K_ILL = 6;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] InstrD = '0, PCD = '0, PCPlus4D = '0, ResultW = '0;
    logic        RegWriteW = 1'b0, FlushE = 1'b0;
    logic [4:0]  RdW = '0;
    logic [4:0]  Rs1D, Rs2D, Rs1E, Rs2E, RdE;
    logic [31:0] RD1E, RD2E, ImmExtE, PCE, PCPlus4E;
    logic        RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE, IllegalE;
    logic [1:0]  ResultSrcE;
    logic [2:0]  ALUControlE;

    always #5 clk = ~clk;

    id_stage dut (
        .clk(clk), .reset(reset), .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D),
        .RegWriteW(RegWriteW), .RdW(RdW), .ResultW(ResultW), .FlushE(FlushE),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .RD1E(RD1E), .RD2E(RD2E), .ImmExtE(ImmExtE),
        .PCE(PCE), .PCPlus4E(PCPlus4E), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
        .RegWriteE(RegWriteE), .ResultSrcE(ResultSrcE), .MemWriteE(MemWriteE),
        .JumpE(JumpE), .BranchE(BranchE), .ALUControlE(ALUControlE),
        .ALUSrcE(ALUSrcE), .IllegalE(IllegalE)
    );

    typedef struct {
        logic [31:0] rd1, rd2, imm, pc, pc4;
        logic [4:0]  rs1, rs2, rd;
        logic        regw, memw, jump, branch, alusrc, ill;
        logic [1:0]  rsrc;
        logic [2:0]  alu;
        bit          chk_data, chk_imm;
        string       tag;
    } exp_t;

    exp_t        q[$];
    int          vectors = 0;
    int          miscompares = 0;
    logic [31:0] mregs [32];

    function automatic logic [31:0] encode(int kind, logic [4:0] rd, logic [4:0] rs1,
                                           logic [4:0] rs2, logic [2:0] f3, logic f7b,
                                           int imm, logic [6:0] illop);
        logic [31:0] u;
        u = 32'(imm);
        case (kind)
            K_LW:    return {u[11:0], rs1, 3'b010, rd, 7'b0000011};
            K_SW:    return {u[11:5], rs2, rs1, 3'b010, u[4:0], 7'b0100011};
            K_R:     return {1'b0, f7b, 5'b00000, rs2, rs1, f3, rd, 7'b0110011};
            K_I:     return {u[11:0], rs1, f3, rd, 7'b0010011};
            K_BEQ:   return {u[12], u[10:5], rs2, rs1, 3'b000, u[4:1], u[11], 7'b1100011};
            K_JAL:   return {u[20], u[10:1], u[11], u[19:12], rd, 7'b1101111};
            default: return {u[24:0], illop};
        endcase
    endfunction

    // Control signals implied by the mnemonic, independent of any encoding detail.
    function automatic void expect_ctl(int kind, logic [2:0] f3, logic f7b, inout exp_t e);
        e.regw = 0; e.rsrc = 2'b00; e.memw = 0; e.jump = 0; e.branch = 0;
        e.alu = 3'b000; e.alusrc = 0; e.ill = 0;
        case (kind)
            K_LW:  begin e.regw = 1; e.rsrc = 2'b01; e.alusrc = 1; end
            K_SW:  begin e.memw = 1; e.alusrc = 1; end
            K_BEQ: begin e.branch = 1; e.alu = 3'b001; end
            K_JAL: begin e.regw = 1; e.jump = 1; e.rsrc = 2'b10; end
            K_R, K_I: begin
                e.regw = 1;
                e.alusrc = (kind == K_I);
                if (f3 == 3'd0)      e.alu = (kind == K_R && f7b) ? 3'b001 : 3'b000;
                else if (f3 == 3'd2) e.alu = 3'b101;
                else if (f3 == 3'd6) e.alu = 3'b011;
                else if (f3 == 3'd7) e.alu = 3'b010;
                else                 e.ill = 1;
            end
            default: e.ill = 1;
        endcase
    endfunction

    function automatic logic [31:0] model_read(logic [4:0] r, logic we, logic [4:0] wa,
                                               logic [31:0] wd);
        if (r == 0) return 32'h0;
        if (we && wa == r) return wd;
        return mregs[r];
    endfunction

    task automatic step(input int kind, input logic [4:0] rd, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic [2:0] f3, input logic f7b,
                        input int imm, input logic [6:0] illop, input logic [31:0] pc,
                        input logic we, input logic [4:0] wa, input logic [31:0] wd,
                        input logic flush, input logic rstn, input string tag);
        exp_t        e;
        logic [31:0] instr;
        @(negedge clk);
        instr     = encode(kind, rd, rs1, rs2, f3, f7b, imm, illop);
        InstrD    = instr;
        PCD       = pc;
        PCPlus4D  = pc + 32'd4;
        RegWriteW = we;
        RdW       = wa;
        ResultW   = wd;
        FlushE    = flush;
        reset     = rstn;
        #1;
        vectors++;
        if (Rs1D !== instr[19:15] || Rs2D !== instr[24:20]) begin
            miscompares++;
            $display("FAIL %s rs_fields: got rs1=%0d rs2=%0d exp rs1=%0d rs2=%0d",
                     tag, Rs1D, Rs2D, instr[19:15], instr[24:20]);
        end
        e.tag = tag;
        if (!rstn) begin
            e.rd1 = 0; e.rd2 = 0; e.imm = 0; e.pc = 0; e.pc4 = 0;
            e.rs1 = 0; e.rs2 = 0; e.rd = 0;
            expect_ctl(K_ILL, 3'd0, 1'b0, e);
            e.ill = 0;
            e.chk_data = 1; e.chk_imm = 1;
            for (int i = 0; i < 32; i++) mregs[i] = 32'h0;
        end else begin
            e.rs1 = instr[19:15]; e.rs2 = instr[24:20]; e.rd = instr[11:7];
            e.rd1 = model_read(e.rs1, we, wa, wd);
            e.rd2 = model_read(e.rs2, we, wa, wd);
            e.pc  = pc;
            e.pc4 = pc + 32'd4;
            e.imm = (kind == K_R) ? 32'h0 : 32'(imm);
            expect_ctl(kind, f3, f7b, e);
            if (flush) begin
                expect_ctl(K_ILL, 3'd0, 1'b0, e);
                e.ill = 0;
            end
            e.chk_data = !flush;
            e.chk_imm  = !flush && (kind != K_ILL);
            if (we && wa != 0) mregs[wa] = wd;
        end
        q.push_back(e);
    endtask

    function automatic void cmp(string name, logic [31:0] got, logic [31:0] exp,
                                inout int nbad, inout string msg);
        if (got !== exp) begin
            if (nbad < 5) msg = {msg, $sformatf(" %s got=%h exp=%h", name, got, exp)};
            nbad++;
        end
    endfunction

    // Monitor: one ID/EX result per rising edge, sampled just after it.
    always @(posedge clk) begin
        exp_t  e;
        int    nbad;
        string msg;
        #1;
        if (q.size() > 0) begin
            e = q.pop_front();
            nbad = 0;
            msg = "";
            vectors++;
            cmp("RegWriteE", 32'(RegWriteE), 32'(e.regw), nbad, msg);
            cmp("ResultSrcE", 32'(ResultSrcE), 32'(e.rsrc), nbad, msg);
            cmp("MemWriteE", 32'(MemWriteE), 32'(e.memw), nbad, msg);
            cmp("JumpE", 32'(JumpE), 32'(e.jump), nbad, msg);
            cmp("BranchE", 32'(BranchE), 32'(e.branch), nbad, msg);
            cmp("ALUControlE", 32'(ALUControlE), 32'(e.alu), nbad, msg);
            cmp("ALUSrcE", 32'(ALUSrcE), 32'(e.alusrc), nbad, msg);
            cmp("IllegalE", 32'(IllegalE), 32'(e.ill), nbad, msg);
            if (e.chk_imm) cmp("ImmExtE", ImmExtE, e.imm, nbad, msg);
            if (e.chk_data) begin
                cmp("RD1E", RD1E, e.rd1, nbad, msg);
                cmp("RD2E", RD2E, e.rd2, nbad, msg);
                cmp("PCE", PCE, e.pc, nbad, msg);
                cmp("PCPlus4E", PCPlus4E, e.pc4, nbad, msg);
                cmp("Rs1E", 32'(Rs1E), 32'(e.rs1), nbad, msg);
                cmp("Rs2E", 32'(Rs2E), 32'(e.rs2), nbad, msg);
                cmp("RdE", 32'(RdE), 32'(e.rd), nbad, msg);
            end
            if (nbad > 0) begin
                miscompares++;
                $display("FAIL %s:%s", e.tag, msg);
            end
        end
    end

    initial begin
        int          kind, imm;
        logic [2:0]  f3;
        logic [6:0]  illop;
        logic [31:0] pc;
        bit          rstn;

        // Reset held low: writes ignored, outputs stay zero.
        for (int i = 0; i < 3; i++)
            step(K_I, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 5, 7'h0, 32'h40, 1'b1, 5'd1,
                 32'h55, 1'b0, 1'b0, "reset_hold");
        step(K_R, 5'd2, 5'd1, 5'd1, 3'd0, 1'b0, 0, 7'h0, 32'h44, 1'b0, 5'd0, 0, 1'b0, 1'b1,
             "x1_after_reset");
        step(K_R, 5'd4, 5'd3, 5'd3, 3'd0, 1'b0, 0, 7'h0, 32'h48, 1'b1, 5'd3,
             32'hDEADBEEF, 1'b0, 1'b1, "bypass_add");
        step(K_R, 5'd5, 5'd3, 5'd0, 3'd0, 1'b1, 0, 7'h0, 32'h4C, 1'b0, 5'd0, 0, 1'b0, 1'b1,
             "regfile_sub");
        step(K_R, 5'd5, 5'd0, 5'd0, 3'd0, 1'b0, 0, 7'h0, 32'h50, 1'b1, 5'd0, 32'h1234,
             1'b0, 1'b1, "x0_write_bypass");
        step(K_R, 5'd5, 5'd0, 5'd3, 3'd7, 1'b0, 0, 7'h0, 32'h54, 1'b0, 5'd0, 0, 1'b0, 1'b1,
             "x0_read");
        step(K_SW, 5'd0, 5'd1, 5'd2, 3'd2, 1'b0, -4, 7'h0, 32'h58, 1'b0, 5'd0, 0, 1'b0, 1'b1,
             "sw_neg4");
        step(K_BEQ, 5'd0, 5'd1, 5'd2, 3'd0, 1'b0, -8, 7'h0, 32'h5C, 1'b0, 5'd0, 0, 1'b0, 1'b1,
             "beq_neg8");
        step(K_JAL, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 2048, 7'h0, 32'h100, 1'b0, 5'd0, 0, 1'b0,
             1'b1, "jal_2048");
        step(K_LW, 5'd6, 5'd1, 5'd0, 3'd2, 1'b0, 16, 7'h0, 32'h104, 1'b1, 5'd7, 32'h77, 1'b1,
             1'b1, "flush_lw");
        step(K_R, 5'd1, 5'd7, 5'd7, 3'd6, 1'b0, 0, 7'h0, 32'h108, 1'b0, 5'd0, 0, 1'b0, 1'b1,
             "write_during_flush");
        step(K_ILL, 5'd0, 5'd0, 5'd0, 3'd0, 1'b0, 32'h0123456, 7'h7F, 32'h10C, 1'b0, 5'd0, 0,
             1'b0, 1'b1, "illegal_7f");
        step(K_I, 5'd2, 5'd1, 5'd0, 3'd1, 1'b0, 3, 7'h0, 32'h110, 1'b0, 5'd0, 0, 1'b0, 1'b1,
             "illegal_funct3");

        // Randomized program with a mid-run reset pulse.
        for (int n = 0; n < 400; n++) begin
            kind = int'($urandom_range(0, 6));
            f3   = 3'($urandom_range(0, 7));
            case (kind)
                K_BEQ:   imm = 2 * (int'($urandom_range(0, 4095)) - 2048);
                K_JAL:   imm = 2 * (int'($urandom_range(0, 1048575)) - 524288);
                K_ILL:   imm = int'($urandom);
                default: imm = int'($urandom_range(0, 4095)) - 2048;
            endcase
            do illop = 7'($urandom);
            while (illop inside {7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011,
                                 7'b1100011, 7'b1101111});
            pc   = $urandom & 32'hFFFF_FFFC;
            rstn = !(n >= 200 && n < 202);
            step(kind, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                 5'($urandom_range(0, 7)), f3, 1'($urandom), imm, illop, pc,
                 1'($urandom_range(0, 9) < 6), 5'($urandom_range(0, 7)), $urandom,
                 1'($urandom_range(0, 9) == 0), rstn, $sformatf("rand%0d", n));
        end

        repeat (3) @(negedge clk);
        vectors++;
        if (q.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_drain: got %0d pending entries, exp 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
